uart_program_loader: RTL

Boot-time loader that receives a MIPS program over an 8N1 UART line and writes it word-by-word into the instruction memory that feeds the processor's program counter fetch path. It holds the processor core in reset while loading and releases it only after the full image is stored. This lets the team change programs without resynthesizing `ProgramMemory` contents.

---
 rtl/uart_program_loader_if.sv | 18 +
 rtl/uart_program_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader_if.sv
// Instruction-memory write port driven by the UART program loader.
interface uart_program_loader_if;
  logic        ProgWrite;
  logic [31:0] ProgAddress;
  logic [31:0] ProgData;

  modport master (
    output ProgWrite,
    output ProgAddress,
    output ProgData
  );

  modport slave (
    input ProgWrite,
    input ProgAddress,
    input ProgData
  );
endinterface

// File: rtl/uart_program_loader.sv
// UART 8N1 boot loader: count byte, then big-endian words into program memory.
// Optional trailing 8-bit payload checksum with `define LOADER_CHECKSUM_EN.
module uart_program_loader #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD_RATE    = 115200,
  parameter int MEMORY_DEPTH = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  uart_program_loader_if.master prog,
  output logic cpu_reset,
  output logic load_done,
  output logic load_error
);

  localparam int CPB  = CLK_FREQ / BAUD_RATE;
  localparam int CW   = $clog2(CPB + 1);
  localparam int IDXW = $clog2(MEMORY_DEPTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rx_st_t;

  typedef enum logic [2:0] {
    S_COUNT, S_LOAD, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } st_t;

  logic          rx_s1_q, rx_s2_q;
  rx_st_t        rx_st_q, rx_st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          byte_valid, frame_err;

  st_t             st_q, st_d;
  logic [IDXW-1:0] n_q, n_d;
  logic [IDXW-1:0] widx_q, widx_d, widx_inc;
  logic [1:0]      bidx_q, bidx_d;
  logic [31:0]     word_q, word_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      sum_q, sum_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_st_q <= R_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_st_q <= rx_st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  // Stop-bit sample returns straight to idle so back-to-back bytes are caught
  always_comb begin
    rx_st_d    = rx_st_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (rx_st_q)
      R_IDLE: begin
        if (!rx_s2_q) begin
          rx_st_d = R_START;
          cnt_d   = '0;
        end
      end
      R_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          rx_st_d = rx_s2_q ? R_IDLE : R_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          sh_d  = {rx_s2_q, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) rx_st_d = R_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d      = '0;
          byte_valid = rx_s2_q;
          frame_err  = !rx_s2_q;
          rx_st_d    = R_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: rx_st_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q   <= S_COUNT;
      n_q    <= '0;
      widx_q <= '0;
      bidx_q <= '0;
      word_q <= '0;
      addr_q <= '0;
      data_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q  <= '0;
`endif
    end else begin
      st_q   <= st_d;
      n_q    <= n_d;
      widx_q <= widx_d;
      bidx_q <= bidx_d;
      word_q <= word_d;
      addr_q <= addr_d;
      data_q <= data_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q  <= sum_d;
`endif
    end
  end

  always_comb begin
    st_d     = st_q;
    n_d      = n_q;
    widx_d   = widx_q;
    bidx_d   = bidx_q;
    word_d   = word_q;
    addr_d   = addr_q;
    data_d   = data_q;
    widx_inc = widx_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
    sum_d    = sum_q;
`endif
    unique case (st_q)
      S_COUNT: begin
        if (frame_err) begin
          st_d = S_ERROR;
        end else if (byte_valid) begin
          if (sh_q == 8'd0 || int'(sh_q) > MEMORY_DEPTH) begin
            st_d = S_ERROR;
          end else begin
            n_d    = IDXW'(sh_q);
            widx_d = '0;
            bidx_d = '0;
`ifdef LOADER_CHECKSUM_EN
            sum_d  = '0;
`endif
            st_d   = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (frame_err) begin
          st_d = S_ERROR;
        end else if (byte_valid) begin
          word_d = {word_q[23:0], sh_q};
          bidx_d = bidx_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d  = sum_q + sh_q;
`endif
          if (bidx_q == 2'd3) begin
            addr_d = {{(30-IDXW){1'b0}}, widx_q, 2'b00};
            data_d = {word_q[23:0], sh_q};
            st_d   = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        widx_d = widx_inc;
        bidx_d = '0;
        if (frame_err) begin
          st_d = S_ERROR;
        end else if (widx_inc == n_q) begin
`ifdef LOADER_CHECKSUM_EN
          st_d = S_CHECK;
`else
          st_d = S_DONE;
`endif
        end else begin
          st_d = S_LOAD;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (frame_err) begin
          st_d = S_ERROR;
        end else if (byte_valid) begin
          st_d = (sh_q == sum_q) ? S_DONE : S_ERROR;
        end
      end
`endif
      S_DONE:  st_d = S_DONE;
      S_ERROR: st_d = S_ERROR;
      default: st_d = S_ERROR;
    endcase
  end

  assign prog.ProgWrite   = (st_q == S_WRITE);
  assign prog.ProgAddress = addr_q;
  assign prog.ProgData    = data_q;
  assign cpu_reset        = (st_q != S_DONE);
  assign load_done        = (st_q == S_DONE);
  assign load_error       = (st_q == S_ERROR);

endmodule
